// File: rtl/cl_mem_arbiter_pkg.sv
// Shared constants for the cache-line memory arbiter: FSM encodings, port ids, line width.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cl_mem_arbiter_pkg;

    // Default cache-line width; must match the caches and the atomic unit.
    localparam int CLP = 128;

    // Transaction FSM encodings.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    // Port identifiers used by the grant register and the round-robin pointer.
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/cl_req_slot.sv
// Request latch for one cache-line master: captures addr/rw/data on strobe, holds a pending flag.
// Latency: req_o/addr_o reflect a strobe in the same cycle, so an idle arbiter can grant with no extra cycle.
// Backpressure: a strobe while pending (queued or in service) is dropped; pending clears on the completing edge.
module cl_req_slot
    import cl_mem_arbiter_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int CLSIZE = CLP
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              strobe_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic              rw_i,
    input  logic [CLSIZE-1:0] data_i,
    input  logic              clear_i,
    output logic              req_o,
    output logic [XLEN-1:0]   addr_o,
    output logic              rw_o,
    output logic [CLSIZE-1:0] data_o
);

    logic              pend_q;
    logic [XLEN-1:0]   addr_q;
    logic              rw_q;
    logic [CLSIZE-1:0] data_q;
    logic              capture;

    // A new request is accepted only when nothing is outstanding on this port.
    assign capture = strobe_i && !pend_q;

    // Latch the request fields and track the pending flag until the arbiter completes it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= 1'b0;
            addr_q <= '0;
            rw_q   <= 1'b0;
            data_q <= '0;
        end else if (capture) begin
            pend_q <= 1'b1;
            addr_q <= addr_i;
            rw_q   <= rw_i;
            data_q <= data_i;
        end else if (clear_i) begin
            pend_q <= 1'b0;
        end
    end

    // Present either the latched request or, when nothing is latched yet, the live strobe fields.
    assign req_o  = pend_q | strobe_i;
    assign addr_o = pend_q ? addr_q : addr_i;
    assign rw_o   = pend_q ? rw_q   : rw_i;
    assign data_o = pend_q ? data_q : data_i;

endmodule

// File: rtl/cl_mem_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto one memory strobe/done port; optional ARB_ROUND_ROBIN_EN.
// Latency: strobe at edge N -> m_strobe_o from N+1; m_done_i in cycle M -> requester done in M+1; 1 idle cycle between.
// Backpressure: one transaction in flight; each port holds at most one pending request, extra strobes are dropped.
module cl_mem_arbiter
    import cl_mem_arbiter_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int CLSIZE = CLP
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // I-side (read only)
    input  logic              i_strobe_i,
    input  logic [XLEN-1:0]   i_addr_i,
    output logic              i_done_o,
    output logic [CLSIZE-1:0] i_data_o,
    // D-side
    input  logic              d_strobe_i,
    input  logic [XLEN-1:0]   d_addr_i,
    input  logic              d_rw_i,
    input  logic [CLSIZE-1:0] d_data_i,
    output logic              d_done_o,
    output logic [CLSIZE-1:0] d_data_o,
    // Memory master
    output logic              m_strobe_o,
    output logic [XLEN-1:0]   m_addr_o,
    output logic              m_rw_o,
    output logic [CLSIZE-1:0] m_data_o,
    input  logic              m_done_i,
    input  logic [CLSIZE-1:0] m_data_i
);

    logic [1:0]        state_q;
    logic              grant_q;
    logic              grant_n;
    logic              any_req;
    logic              xfer_done;
    logic [CLSIZE-1:0] rsp_q;

    logic              i_req;
    logic [XLEN-1:0]   i_addr_sel;
    logic              i_rw_sel;
    logic [CLSIZE-1:0] i_data_sel;
    logic              i_clr;

    logic              d_req;
    logic [XLEN-1:0]   d_addr_sel;
    logic              d_rw_sel;
    logic [CLSIZE-1:0] d_data_sel;
    logic              d_clr;

    // Memory completion only counts while a transaction is actually on the bus.
    assign xfer_done = (state_q == ST_ISSUE) && m_done_i;
    assign i_clr     = xfer_done && (grant_q == PORT_I);
    assign d_clr     = xfer_done && (grant_q == PORT_D);

    // The instruction side never writes, so its direction and write line are tied off.
    cl_req_slot #(.XLEN(XLEN), .CLSIZE(CLSIZE)) u_i_slot (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .strobe_i (i_strobe_i),
        .addr_i   (i_addr_i),
        .rw_i     (1'b0),
        .data_i   ({CLSIZE{1'b0}}),
        .clear_i  (i_clr),
        .req_o    (i_req),
        .addr_o   (i_addr_sel),
        .rw_o     (i_rw_sel),
        .data_o   (i_data_sel)
    );

    cl_req_slot #(.XLEN(XLEN), .CLSIZE(CLSIZE)) u_d_slot (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .strobe_i (d_strobe_i),
        .addr_i   (d_addr_i),
        .rw_i     (d_rw_i),
        .data_i   (d_data_i),
        .clear_i  (d_clr),
        .req_o    (d_req),
        .addr_o   (d_addr_sel),
        .rw_o     (d_rw_sel),
        .data_o   (d_data_sel)
    );

    assign any_req = i_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_ptr_q;

    // Priority goes to the port that was not served by the last completed transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= PORT_D;
        end else if (xfer_done) begin
            rr_ptr_q <= ~grant_q;
        end
    end

    // Contended requests follow the pointer; a lone request wins outright.
    always_comb begin
        grant_n = PORT_D;
        if (i_req && d_req) begin
            grant_n = rr_ptr_q;
        end else if (i_req) begin
            grant_n = PORT_I;
        end
    end
`else
    // Fixed priority: the data side always wins when it is requesting.
    always_comb begin
        grant_n = PORT_D;
        if (!d_req) begin
            grant_n = PORT_I;
        end
    end
`endif

    // Transaction FSM: grant and load the bus in IDLE, wait for memory in ISSUE, answer in RESP.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            grant_q  <= PORT_D;
            m_addr_o <= '0;
            m_rw_o   <= 1'b0;
            m_data_o <= '0;
            rsp_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_q <= grant_n;
                        if (grant_n == PORT_D) begin
                            m_addr_o <= d_addr_sel;
                            m_rw_o   <= d_rw_sel;
                            m_data_o <= d_data_sel;
                        end else begin
                            m_addr_o <= i_addr_sel;
                            m_rw_o   <= i_rw_sel;
                            m_data_o <= i_data_sel;
                        end
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (m_done_i) begin
                        rsp_q   <= m_data_i;
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobe and done pulses decode straight from state, so reset removes them asynchronously.
    assign m_strobe_o = (state_q == ST_ISSUE);
    assign i_done_o   = (state_q == ST_RESP) && (grant_q == PORT_I);
    assign d_done_o   = (state_q == ST_RESP) && (grant_q == PORT_D);
    assign i_data_o   = rsp_q;
    assign d_data_o   = rsp_q;

endmodule
